mssd_frame_sched: RTL and testbench

//  Round-robin frame scheduler that shares the single serial line into the MSSD demux among NREQ requesters.

---
 rtl/mssd_pkg.sv | 18 +
 rtl/mssd_rr_arbiter.sv | 29 ++
 rtl/mssd_frame_sched.sv | 195 +++++++++++++++++++
 tb/tb_mssd_frame_sched.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mssd_pkg.sv
// Shared constants and state encoding for the MSSD frame scheduler.
package mssd_pkg;

    localparam int unsigned ADDR_W    = 2;
    localparam logic        START_BIT = 1'b0;
    localparam logic        IDLE_BIT  = 1'b1;
    localparam int unsigned HDR_BITS  = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        LEN,
        DATA,
        GAP
    } sched_state_t;

endpackage

// File: rtl/mssd_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above ptr, wrapping modulo NREQ.
module mssd_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant_c,
    output logic             valid_c
);

    logic             found;
    logic [PTR_W-1:0] j;

    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        j       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = PTR_W'((32'(ptr) + k) % NREQ);
            if (!found && req[j]) begin
                grant_c[j] = 1'b1;
                found      = 1'b1;
            end
        end
        valid_c = found;
    end

endmodule

// File: rtl/mssd_frame_sched.sv
// Round-robin frame scheduler serialising requester frames onto the MSSD serial line.
// Optional MSSD_SCHED_GAP_EN inserts GAP_CYCLES idle cycles after every frame.
module mssd_frame_sched
    import mssd_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ*ADDR_W-1:0]              dest,
    input  logic [NREQ*LEN_W-1:0]               len,
    input  logic [NREQ*((1 << LEN_W) - 1)-1:0]  data,
    output logic [NREQ-1:0]                     gnt,
    output logic [NREQ-1:0]                     done,
    output logic                                serOut,
    output logic                                busy
);

    localparam int unsigned PTR_W  = $clog2(NREQ);
    localparam int unsigned DATA_W = (1 << LEN_W) - 1;
    localparam int unsigned HDR_W  = ADDR_W + LEN_W;

    sched_state_t      state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [HDR_W-1:0]  hdr_q, hdr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [NREQ-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_d, done_d;
    logic              ser_d, busy_d;
    logic              last_c;

    logic [NREQ-1:0]   grant_c;
    logic              valid_c;
    logic [PTR_W-1:0]  win_c;

`ifdef MSSD_SCHED_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    logic unused_gap;
    assign unused_gap = ^GAP_CYCLES;
`endif

    mssd_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .grant_c (grant_c),
        .valid_c (valid_c)
    );

    // Winner index for field selection and pointer update
    always_comb begin
        win_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_c[k]) win_c = PTR_W'(k);
        end
    end

    // Next state; header goes out MSB first from a shift copy, payload LSB first
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        len_d   = len_q;
        sh_d    = sh_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        done_d  = '0;
        ser_d   = IDLE_BIT;
        last_c  = 1'b0;
`ifdef MSSD_SCHED_GAP_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    state_d = START;
                    ser_d   = START_BIT;
                    gnt_d   = grant_c;
                    owner_d = grant_c;
                    hdr_d   = {dest[32'(win_c)*ADDR_W +: ADDR_W], len[32'(win_c)*LEN_W +: LEN_W]};
                    len_d   = len[32'(win_c)*LEN_W +: LEN_W];
                    sh_d    = data[32'(win_c)*DATA_W +: DATA_W];
                    ptr_d   = (32'(win_c) == NREQ - 1) ? '0 : win_c + PTR_W'(1);
                end
            end
            START: begin
                state_d = ADDR;
                cnt_d   = LEN_W'(ADDR_W - 1);
                ser_d   = hdr_q[HDR_W-1];
                hdr_d   = hdr_q << 1;
            end
            ADDR: begin
                ser_d = hdr_q[HDR_W-1];
                hdr_d = hdr_q << 1;
                if (cnt_q == '0) begin
                    state_d = LEN;
                    cnt_d   = LEN_W'(LEN_W - 1);
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            LEN: begin
                if (cnt_q != '0) begin
                    ser_d = hdr_q[HDR_W-1];
                    hdr_d = hdr_q << 1;
                    cnt_d = cnt_q - LEN_W'(1);
                end else if (len_q == '0) begin
                    last_c = 1'b1;
                end else begin
                    state_d = DATA;
                    ser_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    cnt_d   = len_q - LEN_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    last_c = 1'b1;
                end else begin
                    ser_d = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            GAP: begin
`ifdef MSSD_SCHED_GAP_EN
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - GAP_W'(1);
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Frame complete: report to owner and drop back to the line-idle side
        if (last_c) begin
            done_d = owner_q;
`ifdef MSSD_SCHED_GAP_EN
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYCLES - 1);
`else
            state_d = IDLE;
`endif
        end

        busy_d = (state_d == START) || (state_d == ADDR) ||
                 (state_d == LEN)   || (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hdr_q   <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt     <= '0;
            done    <= '0;
            serOut  <= IDLE_BIT;
            busy    <= 1'b0;
`ifdef MSSD_SCHED_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt     <= gnt_d;
            done    <= done_d;
            serOut  <= ser_d;
            busy    <= busy_d;
`ifdef MSSD_SCHED_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

endmodule

// File: tb/tb_mssd_frame_sched.sv
// Directed self-checking bench for mssd_frame_sched (NREQ=4, LEN_W=4, GAP_CYCLES=2).
module tb_mssd_frame_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  dest;
    logic [15:0] len;
    logic [59:0] data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        serOut;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef MSSD_SCHED_GAP_EN
    localparam int EXP_IDLE = 3;
`else
    localparam int EXP_IDLE = 1;
`endif

    mssd_frame_sched #(
        .NREQ       (4),
        .LEN_W      (4),
        .GAP_CYCLES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .dest   (dest),
        .len    (len),
        .data   (data),
        .gnt    (gnt),
        .done   (done),
        .serOut (serOut),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = 4'b1111;
        tick;
        tick;
        checks++; if (serOut !== 1'b1)  begin errors++; $display("FAIL reset_ser got %b exp 1", serOut); end
        checks++; if (gnt !== 4'b0000)  begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b exp 0000", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        req = 4'b0000;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_frame;
        logic [9:0] exp_v;
        int         busy_cnt;
        do_reset;
        dest  = 8'b0000_0010;
        len   = 16'h0003;
        data  = 60'h5;
        req   = 4'b0001;
        exp_v = 10'b0100011101;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i == 0) begin
                checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t1_gnt got %b exp 0001", gnt); end
                req = 4'b0000;
                data = 60'h0;
            end else begin
                checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL t1_gnt_pulse cyc %0d got %b exp 0000", i, gnt); end
            end
            checks++; if (serOut !== exp_v[9]) begin errors++; $display("FAIL t1_ser bit %0d got %b exp %b", i, serOut, exp_v[9]); end
            checks++; if (done !== 4'b0000) begin errors++; $display("FAIL t1_done_early cyc %0d got %b exp 0000", i, done); end
            if (busy === 1'b1) busy_cnt++;
            exp_v = exp_v << 1;
        end
        tick;
        checks++; if (done !== 4'b0001) begin errors++; $display("FAIL t1_done got %b exp 0001", done); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL t1_busy_end got %b exp 0", busy); end
        checks++; if (serOut !== 1'b1)  begin errors++; $display("FAIL t1_ser_idle got %b exp 1", serOut); end
        checks++; if (busy_cnt != 10)   begin errors++; $display("FAIL t1_busy_len got %0d exp 10", busy_cnt); end
        tick;
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL t1_done_pulse got %b exp 0000", done); end
    endtask

    task automatic test_round_robin;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int exp_run   [4] = '{8, 9, 7, 11};
        int order     [5];
        int ng, run, idle, nrun;
        do_reset;
        dest = {2'd3, 2'd2, 2'd1, 2'd0};
        len  = {4'd4, 4'd0, 4'd2, 4'd1};
        data = {45'h0, 15'h1};
        req  = 4'b1111;
        ng = 0; run = 0; idle = 0; nrun = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick;
            if (gnt !== 4'b0000) begin
                checks++; if (!$onehot(gnt)) begin errors++; $display("FAIL t2_onehot got %b exp one-hot", gnt); end
                if (ng > 0) begin
                    checks++; if (idle != EXP_IDLE) begin errors++; $display("FAIL t2_idle gap %0d got %0d exp %0d", ng, idle, EXP_IDLE); end
                end
                for (int k = 0; k < 4; k++) if (gnt[k]) order[ng] = k;
                ng++;
                idle = 0;
                if (ng == 5) break;
            end
            if (busy === 1'b1) begin
                run++;
            end else begin
                if (run > 0 && nrun < 4) begin
                    checks++; if (run != exp_run[nrun]) begin errors++; $display("FAIL t2_run frame %0d got %0d exp %0d", nrun, run, exp_run[nrun]); end
                    nrun++;
                end
                run = 0;
                idle++;
            end
        end
        checks++; if (ng != 5) begin errors++; $display("FAIL t2_timeout grants got %0d exp 5", ng); end
        for (int k = 0; k < 5; k++) begin
            if (k < ng) begin
                checks++; if (order[k] != exp_order[k]) begin errors++; $display("FAIL t2_order slot %0d got %0d exp %0d", k, order[k], exp_order[k]); end
            end
        end
        req = 4'b0000;
        for (int cyc = 0; cyc < 40 && busy === 1'b1; cyc++) tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_drain busy got %b exp 0", busy); end
        tick;
    endtask

    task automatic test_zero_len;
        logic [6:0] exp_v;
        do_reset;
        dest  = 8'b0000_1100;
        len   = 16'h0000;
        data  = 60'h7FFF_8000;
        req   = 4'b0010;
        exp_v = 7'b0110000;
        for (int i = 0; i < 7; i++) begin
            tick;
            if (i == 0) begin
                checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL t3_gnt got %b exp 0010", gnt); end
                req = 4'b0000;
            end
            checks++; if (serOut !== exp_v[6]) begin errors++; $display("FAIL t3_ser bit %0d got %b exp %b", i, serOut, exp_v[6]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t3_busy cyc %0d got %b exp 1", i, busy); end
            exp_v = exp_v << 1;
        end
        tick;
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL t3_done got %b exp 0010", done); end
        checks++; if (serOut !== 1'b1)  begin errors++; $display("FAIL t3_ser_idle got %b exp 1", serOut); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL t3_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_frame;
        int done0_seen, done1_seen;
        do_reset;
        dest = 8'b0000_1001;
        len  = 16'h0018;
        data = {45'h0, 15'h00A1};
        req  = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (i == 0) req = 4'b0000;
        end
        checks++; if (serOut !== 1'b0) begin errors++; $display("FAIL t4_data_bit2 got %b exp 0", serOut); end
        checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL t4_busy_mid got %b exp 1", busy); end
        rst = 1'b1;
        tick;
        checks++; if (serOut !== 1'b1)  begin errors++; $display("FAIL t4_rst_ser got %b exp 1", serOut); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL t4_rst_busy got %b exp 0", busy); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL t4_rst_done got %b exp 0000", done); end
        rst = 1'b0;
        req = 4'b1010;
        tick;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL t4_gnt_after_rst got %b exp 0010", gnt); end
        checks++; if (serOut !== 1'b0) begin errors++; $display("FAIL t4_start_after_rst got %b exp 0", serOut); end
        req = 4'b0000;
        done0_seen = 0;
        done1_seen = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            tick;
            if (done[0] === 1'b1) done0_seen++;
            if (done[1] === 1'b1) done1_seen++;
        end
        checks++; if (done0_seen != 0) begin errors++; $display("FAIL t4_abandoned_done got %0d exp 0", done0_seen); end
        checks++; if (done1_seen != 1) begin errors++; $display("FAIL t4_done1 got %0d exp 1", done1_seen); end
    endtask

    task automatic test_withdraw;
        int gnt2_seen, other_gnt, busy_cnt, done0_seen;
        do_reset;
        dest = 8'b0000_0010;
        len  = 16'h0005;
        data = 60'h15;
        req  = 4'b0001;
        tick;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL t5_gnt got %b exp 0001", gnt); end
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        gnt2_seen = 0; other_gnt = 0; done0_seen = 0;
        req = 4'b0100;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick;
            if (cyc == 3) req = 4'b0000;
            if (gnt[2] === 1'b1) gnt2_seen++;
            if (gnt !== 4'b0000) other_gnt++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 4'b0001) done0_seen++;
        end
        checks++; if (gnt2_seen != 0)  begin errors++; $display("FAIL t5_gnt2 got %0d exp 0", gnt2_seen); end
        checks++; if (other_gnt != 0)  begin errors++; $display("FAIL t5_extra_gnt got %0d exp 0", other_gnt); end
        checks++; if (busy_cnt != 12)  begin errors++; $display("FAIL t5_busy_cycles got %0d exp 12", busy_cnt); end
        checks++; if (done0_seen != 1) begin errors++; $display("FAIL t5_done0 got %0d exp 1", done0_seen); end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        dest = '0;
        len  = '0;
        data = '0;
        test_reset;
        test_single_frame;
        test_round_robin;
        test_zero_len;
        test_reset_mid_frame;
        test_withdraw;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
